// File: rtl/pe_os_pipelined.sv
// Output-stationary systolic PE: forwards operands south/east, multiplies in stage 1,
// accumulates into a guard-bit accumulator in stage 2 and emits one rounded, saturated result per tile.
module pe_os_pipelined #(
    parameter int BIT_WIDTH  = 16,
    parameter int FRAC_WIDTH = 8,
    parameter int GUARD_BITS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BIT_WIDTH-1:0] data_north,
    input  logic                 valid_north,
    input  logic [BIT_WIDTH-1:0] data_west,
    input  logic                 valid_west,
    input  logic                 first_west,
    input  logic                 last_west,
    output logic [BIT_WIDTH-1:0] data_south,
    output logic                 valid_south,
    output logic [BIT_WIDTH-1:0] data_east,
    output logic                 valid_east,
    output logic                 first_east,
    output logic                 last_east,
    output logic [BIT_WIDTH-1:0] result,
    output logic                 result_valid,
    output logic                 result_sat,
    output logic                 protocol_err
);

    localparam int PROD_WIDTH = 2 * BIT_WIDTH;
    localparam int ACC_WIDTH  = PROD_WIDTH + GUARD_BITS;

    typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

    // Returns {clamped, value}: base + sign-extended product, clamped to the accumulator range.
    function automatic logic [ACC_WIDTH:0] sat_acc(input logic [ACC_WIDTH-1:0] base,
                                                   input logic [PROD_WIDTH-1:0] prod);
        logic [ACC_WIDTH:0] sum;
        sum = {base[ACC_WIDTH-1], base}
            + {{(ACC_WIDTH + 1 - PROD_WIDTH){prod[PROD_WIDTH-1]}}, prod};
        if (sum[ACC_WIDTH] != sum[ACC_WIDTH-1]) begin
            return {1'b1, sum[ACC_WIDTH], {(ACC_WIDTH - 1){~sum[ACC_WIDTH]}}};
        end else begin
            return {1'b0, sum[ACC_WIDTH-1:0]};
        end
    endfunction

    // Returns {clamped, value}: round half up, drop the fractional bits, clamp to the result range.
    function automatic logic [BIT_WIDTH:0] round_sat(input logic [ACC_WIDTH-1:0] a);
        logic        [ACC_WIDTH:0] rnd;
        logic signed [ACC_WIDTH:0] r;
        rnd = '0;
        rnd[FRAC_WIDTH-1] = 1'b1;
        r = $signed({a[ACC_WIDTH-1], a} + rnd);
        r = r >>> FRAC_WIDTH;
        if ((&r[ACC_WIDTH:BIT_WIDTH-1]) || !(|r[ACC_WIDTH:BIT_WIDTH-1])) begin
            return {1'b0, r[BIT_WIDTH-1:0]};
        end else begin
            return {1'b1, r[ACC_WIDTH], {(BIT_WIDTH - 1){~r[ACC_WIDTH]}}};
        end
    endfunction

    logic                         mac_s;
    logic                         mismatch_s;
    logic signed [PROD_WIDTH-1:0] prod_r;
    logic                         prod_v_r;
    logic                         prod_first_r;
    logic                         prod_last_r;
    logic        [ACC_WIDTH-1:0]  acc_r;
    logic                         tile_sat_r;
    state_t                       state_r;
    state_t                       next_state_s;
    logic                         restart_s;
    logic                         seq_err_s;
    logic        [ACC_WIDTH-1:0]  acc_base_s;
    logic        [ACC_WIDTH-1:0]  acc_sum_s;
    logic                         acc_sat_s;
    logic                         tile_sat_next_s;
    logic        [BIT_WIDTH-1:0]  out_val_s;
    logic                         out_sat_s;

    assign mac_s      = valid_north & valid_west;
    assign mismatch_s = valid_north ^ valid_west;

    // Operand forwarding to the south and east neighbours, independent of valids.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_south  <= '0;
            valid_south <= 1'b0;
            data_east   <= '0;
            valid_east  <= 1'b0;
            first_east  <= 1'b0;
            last_east   <= 1'b0;
        end else begin
            data_south  <= data_north;
            valid_south <= valid_north;
            data_east   <= data_west;
            valid_east  <= valid_west;
            first_east  <= first_west;
            last_east   <= last_west;
        end
    end

    // Stage 1: full-width signed product with its tile tags.
    always_ff @(posedge clk) begin
        if (rst) begin
            prod_r       <= '0;
            prod_v_r     <= 1'b0;
            prod_first_r <= 1'b0;
            prod_last_r  <= 1'b0;
        end else if (mac_s) begin
            prod_r       <= $signed(data_west) * $signed(data_north);
            prod_v_r     <= 1'b1;
            prod_first_r <= first_west;
            prod_last_r  <= last_west;
        end else begin
            prod_v_r     <= 1'b0;
        end
    end

    // Tile sequencing state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next state: a stage-2 beat ends the tile on last, otherwise keeps it running.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (prod_v_r && !prod_last_r) next_state_s = RUN;
                else                          next_state_s = IDLE;
            end
            RUN: begin
                if (prod_v_r && prod_last_r) next_state_s = IDLE;
                else                         next_state_s = RUN;
            end
            default: next_state_s = IDLE;
        endcase
    end

    // Stage-2 datapath: a beat in IDLE always starts a tile, even without its first tag.
    always_comb begin
        restart_s                = prod_first_r | (state_r == IDLE);
        seq_err_s                = prod_v_r & (prod_first_r ^ (state_r == IDLE));
        acc_base_s               = restart_s ? '0 : acc_r;
        {acc_sat_s, acc_sum_s}   = sat_acc(acc_base_s, prod_r);
        tile_sat_next_s          = acc_sat_s | (~restart_s & tile_sat_r);
        {out_sat_s, out_val_s}   = round_sat(acc_sum_s);
    end

    // Stage 2: accumulate, convert on the last beat, track sticky protocol errors.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r        <= '0;
            tile_sat_r   <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            result_sat   <= 1'b0;
            protocol_err <= 1'b0;
        end else begin
            if (prod_v_r) begin
                acc_r      <= acc_sum_s;
                tile_sat_r <= tile_sat_next_s;
            end
            if (prod_v_r && prod_last_r) begin
                result       <= out_val_s;
                result_sat   <= out_sat_s | tile_sat_next_s;
                result_valid <= 1'b1;
            end else begin
                result_valid <= 1'b0;
            end
            protocol_err <= protocol_err | mismatch_s | seq_err_s;
        end
    end

endmodule

// File: tb/tb_pe_os_pipelined.sv
// Scoreboard bench for pe_os_pipelined: a longint tile model queues expected results at issue,
// a negedge monitor checks forwarding, result pulses and result holding.
module tb_pe_os_pipelined;

    localparam int  BW   = 16;
    localparam int  FW   = 8;
    localparam longint AMAX = (longint'(1) <<< 35) - 1;
    localparam longint AMIN = -(longint'(1) <<< 35);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [BW-1:0] data_north = '0, data_west = '0;
    logic          valid_north = 1'b0, valid_west = 1'b0, first_west = 1'b0, last_west = 1'b0;
    logic [BW-1:0] data_south, data_east, result;
    logic          valid_south, valid_east, first_east, last_east;
    logic          result_valid, result_sat, protocol_err;

    pe_os_pipelined #(.BIT_WIDTH(BW), .FRAC_WIDTH(FW), .GUARD_BITS(4)) dut (
        .clk(clk), .rst(rst),
        .data_north(data_north), .valid_north(valid_north),
        .data_west(data_west), .valid_west(valid_west),
        .first_west(first_west), .last_west(last_west),
        .data_south(data_south), .valid_south(valid_south),
        .data_east(data_east), .valid_east(valid_east),
        .first_east(first_east), .last_east(last_east),
        .result(result), .result_valid(result_valid),
        .result_sat(result_sat), .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [BW-1:0] res;
        logic          sat;
    } exp_t;

    exp_t          exp_q[$];
    int            checks = 0;
    int            errors = 0;
    longint        m_acc = 0;
    bit            m_tsat = 1'b0, m_in_tile = 1'b0, m_err = 1'b0;
    logic [BW-1:0] last_res = '0;
    logic          last_sat = 1'b0;
    bit            mon_en = 1'b0;
    logic [BW-1:0] f_dn, f_dw;
    logic          f_vn, f_vw, f_first, f_last;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference tile arithmetic on plain integers.
    task automatic model_beat(input logic signed [BW-1:0] dn, input logic signed [BW-1:0] dw,
                              input bit f, input bit l);
        longint p;
        longint r;
        exp_t   e;
        p = longint'(dw) * longint'(dn);
        if ((!f && !m_in_tile) || (f && m_in_tile)) m_err = 1'b1;
        if (f || !m_in_tile) begin
            m_acc  = 0;
            m_tsat = 1'b0;
        end
        m_acc = m_acc + p;
        if (m_acc > AMAX) begin
            m_acc = AMAX; m_tsat = 1'b1;
        end else if (m_acc < AMIN) begin
            m_acc = AMIN; m_tsat = 1'b1;
        end
        if (l) begin
            r = (m_acc + (longint'(1) <<< (FW - 1))) >>> FW;
            e.sat = m_tsat;
            if (r > 32767) begin
                r = 32767; e.sat = 1'b1;
            end else if (r < -32768) begin
                r = -32768; e.sat = 1'b1;
            end
            e.res = r[BW-1:0];
            exp_q.push_back(e);
            m_in_tile = 1'b0;
        end else begin
            m_in_tile = 1'b1;
        end
    endtask

    task automatic cyc(input bit vn, input bit vw, input logic [BW-1:0] dn,
                       input logic [BW-1:0] dw, input bit f, input bit l);
        valid_north = vn; valid_west = vw;
        data_north  = dn; data_west  = dw;
        first_west  = f;  last_west  = l;
        if (vn && vw) model_beat(dn, dw, f, l);
        else if (vn != vw) m_err = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b0, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        valid_north = 1'b0; valid_west = 1'b0;
        exp_q.delete();
        m_acc = 0; m_tsat = 1'b0; m_in_tile = 1'b0; m_err = 1'b0;
        @(posedge clk); #1;
        check("rst_data_south", data_south, 0);
        check("rst_valid_south", valid_south, 0);
        check("rst_data_east", data_east, 0);
        check("rst_valid_east", valid_east, 0);
        check("rst_first_east", first_east, 0);
        check("rst_last_east", last_east, 0);
        check("rst_result", result, 0);
        check("rst_result_valid", result_valid, 0);
        check("rst_result_sat", result_sat, 0);
        check("rst_protocol_err", protocol_err, 0);
        last_res = '0; last_sat = 1'b0;
        rst = 1'b0;
    endtask

    task automatic check_err(input string name);
        idle(3);
        check(name, protocol_err, m_err);
    endtask

    // Expected forwarded values: last cycle's inputs.
    always @(posedge clk) begin
        if (rst) begin
            f_dn <= '0; f_dw <= '0; f_vn <= 1'b0; f_vw <= 1'b0; f_first <= 1'b0; f_last <= 1'b0;
        end else begin
            f_dn <= data_north; f_dw <= data_west; f_vn <= valid_north; f_vw <= valid_west;
            f_first <= first_west; f_last <= last_west;
        end
    end

    // Monitor: forwarding every cycle, scoreboard pop on each result pulse, hold otherwise.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en && !rst) begin
            check("fwd_data_south", data_south, f_dn);
            check("fwd_valid_south", valid_south, f_vn);
            check("fwd_data_east", data_east, f_dw);
            check("fwd_valid_east", valid_east, f_vw);
            check("fwd_first_east", first_east, f_first);
            check("fwd_last_east", last_east, f_last);
            if (result_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result_valid", result_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("result", result, e.res);
                    check("result_sat", result_sat, e.sat);
                    last_res = e.res;
                    last_sat = e.sat;
                end
            end else begin
                check("result_hold", result, last_res);
                check("result_sat_hold", result_sat, last_sat);
            end
        end
    end

    initial begin
        int len;
        int v;
        bit f;
        logic [BW-1:0] dn, dw;
        do_reset();
        mon_en = 1'b1;

        // Q8.8 single-term tiles, signed and rounding cases
        cyc(1, 1, 16'h0200, 16'h0180, 1, 1);
        check_err("err_after_clean_tile");
        cyc(1, 1, 16'h0080, 16'hFF00, 1, 1);
        cyc(1, 1, 16'h0080, 16'h0001, 1, 1);
        idle(3);

        // Four-beat tile: 1.0 + 2.0 - 0.5 + 0.25
        cyc(1, 1, 16'h0100, 16'h0100, 1, 0);
        cyc(1, 1, 16'h0100, 16'h0200, 0, 0);
        cyc(1, 1, 16'h0100, 16'hFF80, 0, 0);
        cyc(1, 1, 16'h0100, 16'h0040, 0, 1);
        idle(3);

        // Output saturation, then a clean tile clears the flag
        cyc(1, 1, 16'h7F00, 16'h7F00, 1, 0);
        cyc(1, 1, 16'h7F00, 16'h7F00, 0, 1);
        cyc(1, 1, 16'h0100, 16'h0100, 1, 1);
        idle(3);

        // Accumulator saturation over a long tile, then recovery
        for (int i = 0; i < 40; i++) cyc(1, 1, 16'h8000, 16'h8000, i == 0, i == 39);
        cyc(1, 1, 16'hFE00, 16'h0300, 1, 1);
        idle(3);

        // Valid mismatch, then reset mid-tile
        cyc(0, 1, 16'h1234, 16'h0100, 1, 1);
        check_err("err_after_mismatch");
        idle(2);
        check("err_sticky", protocol_err, 1);
        cyc(1, 1, 16'h0100, 16'h0500, 1, 0);
        cyc(1, 1, 16'h0100, 16'h0500, 0, 0);
        do_reset();
        cyc(1, 1, 16'h0180, 16'h0100, 1, 0);
        cyc(1, 1, 16'h0040, 16'hFC00, 0, 0);
        cyc(1, 1, 16'h0033, 16'h0011, 0, 1);
        check_err("err_after_reset_tile");

        // Back-to-back tiles with no bubble
        cyc(1, 1, 16'h0200, 16'h0300, 1, 0);
        cyc(1, 1, 16'h0100, 16'h0100, 0, 1);
        cyc(1, 1, 16'hFF00, 16'h0400, 1, 1);
        cyc(1, 1, 16'h0010, 16'h0020, 1, 0);
        cyc(1, 1, 16'h0300, 16'h0300, 0, 1);
        idle(3);

        // Sequence errors: missing first in IDLE, restart inside a tile
        cyc(1, 1, 16'h0100, 16'h0200, 0, 1);
        cyc(1, 1, 16'h0100, 16'h0700, 1, 0);
        cyc(1, 1, 16'h0100, 16'h0300, 1, 1);
        check_err("err_after_seq_error");
        do_reset();

        // Randomised tiles with bubbles, occasional mismatches and missing first tags
        for (int t = 0; t < 200; t++) begin
            len = $urandom_range(1, 6);
            for (int b = 0; b < len; b++) begin
                if ($urandom_range(0, 7) == 0) idle(1);
                if ($urandom_range(0, 39) == 0)
                    cyc(1'($urandom), 1'b0, 16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
                if ($urandom_range(0, 3) == 0) begin
                    v = $urandom_range(0, 1023) - 512; dn = v[BW-1:0];
                    v = $urandom_range(0, 1023) - 512; dw = v[BW-1:0];
                end else begin
                    dn = 16'($urandom); dw = 16'($urandom);
                end
                f = (b == 0) && ($urandom_range(0, 19) != 0);
                cyc(1, 1, dn, dw, f, b == len - 1);
            end
        end
        idle(4);
        check("err_final", protocol_err, m_err);
        check("pending_results", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
